// File: rtl/game_pkg.sv
// Shared encodings and sprite dimensions for the dino game datapath.
// Imported by the collision/score block and its interface consumers.
package game_pkg;

  typedef enum logic [1:0] {
    GS_INIT  = 2'd0,
    GS_START = 2'd1,
    GS_END   = 2'd2,
    GS_RESET = 2'd3
  } game_state_e;

  typedef enum logic [2:0] {
    DT_LOW_BIRD  = 3'd0,
    DT_HIGH_BIRD = 3'd1,
    DT_SMALL     = 3'd2,
    DT_MANY      = 3'd3,
    DT_BIG       = 3'd4,
    DT_NOTHING   = 3'd5
  } danger_type_e;

  typedef enum logic {
    DB_SIT   = 1'b0,
    DB_STAND = 1'b1
  } dino_behavior_e;

  localparam int WINDOW_WIDTH  = 640;
  localparam int WINDOW_HEIGHT = 480;

  localparam int SMALL_W = 19;
  localparam int SMALL_H = 36;
  localparam int MANY_W  = 77;
  localparam int MANY_H  = 49;
  localparam int BIG_W   = 27;
  localparam int BIG_H   = 50;
  localparam int BIRD_W  = 44;
  localparam int BIRD_H  = 33;

  localparam int DINO_STAND_W = 44;
  localparam int DINO_STAND_H = 47;
  localparam int DINO_SIT_W   = 59;
  localparam int DINO_SIT_H   = 30;

endpackage

// File: rtl/collision_score_if.sv
// Object-controller to collision/score bundle: dino, three danger slots,
// game control in; hit flags and BCD scores out.
interface collision_score_if;
  logic       game_tick;
  logic [1:0] game_state;
  logic [9:0] dino_pos;
  logic       dino_behavior;
  logic [9:0] danger_pos1;
  logic [9:0] danger_pos2;
  logic [9:0] danger_pos3;
  logic [2:0] danger_type1;
  logic [2:0] danger_type2;
  logic [2:0] danger_type3;
  logic       danger_en1;
  logic       danger_en2;
  logic       danger_en3;
  logic       hit;
  logic       hit_pulse;
  logic [15:0] score;
  logic [15:0] high_score;

  modport master (
    output game_tick, game_state, dino_pos, dino_behavior,
    output danger_pos1, danger_pos2, danger_pos3,
    output danger_type1, danger_type2, danger_type3,
    output danger_en1, danger_en2, danger_en3,
    input  hit, hit_pulse, score, high_score
  );

  modport slave (
    input  game_tick, game_state, dino_pos, dino_behavior,
    input  danger_pos1, danger_pos2, danger_pos3,
    input  danger_type1, danger_type2, danger_type3,
    input  danger_en1, danger_en2, danger_en3,
    output hit, hit_pulse, score, high_score
  );
endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter: synchronous clear, enable-gated increment,
// holds at 9999 instead of wrapping.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  function automatic logic [15:0] bcd_sat_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = 16'h0000;
    else if (en)
      count_d = bcd_sat_inc(count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= 16'h0000;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/collision_score.sv
// Round-robin pipelined dino/obstacle overlap check with sticky hit and BCD score.
// Define COLLISION_HIGH_SCORE_EN to keep a high score; otherwise it reads as zero.
module collision_score
  import game_pkg::*;
#(
  parameter int DINO_X         = 64,
  parameter int GROUND         = 400,
  parameter int LOW_BIRD_LIFT  = 20,
  parameter int HIGH_BIRD_LIFT = 50,
  parameter int SCORE_DIV      = 6
) (
  input logic               clk,
  input logic               rst,
  collision_score_if.slave  bus
);

  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  function automatic logic [10:0] obs_width(input logic [2:0] t);
    case (danger_type_e'(t))
      DT_LOW_BIRD, DT_HIGH_BIRD: obs_width = 11'(BIRD_W);
      DT_SMALL:                  obs_width = 11'(SMALL_W);
      DT_MANY:                   obs_width = 11'(MANY_W);
      DT_BIG:                    obs_width = 11'(BIG_W);
      default:                   obs_width = 11'd0;
    endcase
  endfunction

  function automatic logic [11:0] obs_height(input logic [2:0] t);
    case (danger_type_e'(t))
      DT_LOW_BIRD, DT_HIGH_BIRD: obs_height = 12'(BIRD_H);
      DT_SMALL:                  obs_height = 12'(SMALL_H);
      DT_MANY:                   obs_height = 12'(MANY_H);
      DT_BIG:                    obs_height = 12'(BIG_H);
      default:                   obs_height = 12'd0;
    endcase
  endfunction

  function automatic logic [11:0] obs_bottom(input logic [2:0] t);
    case (danger_type_e'(t))
      DT_LOW_BIRD:  obs_bottom = 12'(GROUND - LOW_BIRD_LIFT);
      DT_HIGH_BIRD: obs_bottom = 12'(GROUND - HIGH_BIRD_LIFT);
      default:      obs_bottom = 12'(GROUND);
    endcase
  endfunction

  game_state_e gs;
  logic        in_start, in_reset, hit_rise, count_tick, score_inc;
  logic [15:0] score;

  logic [1:0]  idx_q, idx_d;
  logic        sel_en;
  logic [9:0]  sel_pos;
  logic [2:0]  sel_type;

  logic        vld_p1_q, vld_p1_d;
  logic [9:0]  pos_p1_q, pos_p1_d;
  logic [2:0]  type_p1_q, type_p1_d;
  logic [9:0]  dpos_p1_q, dpos_p1_d;
  logic        beh_p1_q, beh_p1_d;

  logic [10:0] dw, ow, pos_x;
  logic [11:0] dh, oh, ob, dino_y;
  logic        x_hit, y_hit, ov_d;

  logic        ov_p2_q, ov_p2_d;
  logic        hit_q, hit_d;
  logic        hit_pulse_q, hit_pulse_d;
  logic [DIV_W-1:0] div_q, div_d;

  assign gs       = game_state_e'(bus.game_state);
  assign in_start = (gs == GS_START);
  assign in_reset = (gs == GS_RESET);

  // Stage 0 -> 1: pick the slot under scan
  always_comb begin
    sel_en   = bus.danger_en1;
    sel_pos  = bus.danger_pos1;
    sel_type = bus.danger_type1;
    case (idx_q)
      2'd1: begin
        sel_en   = bus.danger_en2;
        sel_pos  = bus.danger_pos2;
        sel_type = bus.danger_type2;
      end
      2'd2: begin
        sel_en   = bus.danger_en3;
        sel_pos  = bus.danger_pos3;
        sel_type = bus.danger_type3;
      end
      default: ;
    endcase
  end

  // Stage 1 -> 2: box compare; vertical test is rearranged to additions so
  // a low dino_pos cannot underflow
  always_comb begin
    dw     = (beh_p1_q == DB_STAND) ? 11'(DINO_STAND_W) : 11'(DINO_SIT_W);
    dh     = (beh_p1_q == DB_STAND) ? 12'(DINO_STAND_H) : 12'(DINO_SIT_H);
    ow     = obs_width(type_p1_q);
    oh     = obs_height(type_p1_q);
    ob     = obs_bottom(type_p1_q);
    pos_x  = {1'b0, pos_p1_q};
    dino_y = {2'b00, dpos_p1_q};
    x_hit  = (pos_x > 11'(DINO_X)) && (pos_x < 11'(DINO_X) + dw + ow);
    y_hit  = (dino_y < ob + dh) && (ob < dino_y + oh);
    ov_d   = vld_p1_q && (type_p1_q < 3'(DT_NOTHING)) && x_hit && y_hit;
  end

  // Stage 2 -> 3: hit, scan index, pipeline and score divider next-state
  always_comb begin
    hit_rise   = !in_reset && ov_p2_q && !hit_q;
    count_tick = in_start && bus.game_tick && !hit_q && !hit_rise;
    score_inc  = count_tick && (div_q == DIV_W'(SCORE_DIV - 1));

    idx_d = idx_q;
    if (in_start)
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

    vld_p1_d  = sel_en;
    pos_p1_d  = sel_pos;
    type_p1_d = sel_type;
    dpos_p1_d = bus.dino_pos;
    beh_p1_d  = bus.dino_behavior;
    ov_p2_d   = ov_d;
    if (in_reset) begin
      vld_p1_d  = 1'b0;
      pos_p1_d  = 10'd0;
      type_p1_d = 3'd0;
      dpos_p1_d = 10'd0;
      beh_p1_d  = 1'b0;
      ov_p2_d   = 1'b0;
    end

    hit_d       = !in_reset && (hit_q || ov_p2_q);
    hit_pulse_d = hit_rise;

    div_d = div_q;
    if (in_reset)
      div_d = '0;
    else if (count_tick)
      div_d = score_inc ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= 2'd0;
      vld_p1_q    <= 1'b0;
      pos_p1_q    <= 10'd0;
      type_p1_q   <= 3'd0;
      dpos_p1_q   <= 10'd0;
      beh_p1_q    <= 1'b0;
      ov_p2_q     <= 1'b0;
      hit_q       <= 1'b0;
      hit_pulse_q <= 1'b0;
      div_q       <= '0;
    end else begin
      idx_q       <= idx_d;
      vld_p1_q    <= vld_p1_d;
      pos_p1_q    <= pos_p1_d;
      type_p1_q   <= type_p1_d;
      dpos_p1_q   <= dpos_p1_d;
      beh_p1_q    <= beh_p1_d;
      ov_p2_q     <= ov_p2_d;
      hit_q       <= hit_d;
      hit_pulse_q <= hit_pulse_d;
      div_q       <= div_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (in_reset),
    .en    (score_inc),
    .count (score)
  );

`ifdef COLLISION_HIGH_SCORE_EN
  logic [15:0] high_score_q, high_score_d;

  // Packed BCD orders the same as plain unsigned, so a binary compare suffices
  always_comb begin
    high_score_d = high_score_q;
    if (hit_rise && (score > high_score_q))
      high_score_d = score;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      high_score_q <= 16'h0000;
    else
      high_score_q <= high_score_d;
  end

  assign bus.high_score = high_score_q;
`else
  assign bus.high_score = 16'h0000;
`endif

  assign bus.hit       = hit_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.score     = score;

endmodule

// File: tb/tb_collision_score.sv
// Directed plus randomized bench for collision_score; expectations come from
// a geometric interval model and integer tick arithmetic.
module tb_collision_score;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_score_if bus_if();

  collision_score dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int hs_model = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] hs_exp(input int v);
`ifdef COLLISION_HIGH_SCORE_EN
    return to_bcd(v);
`else
    return (v < 0) ? 16'hffff : 16'h0000;
`endif
  endfunction

  // Sprite geometry as closed intervals on screen
  function automatic int m_ow(input int t);
    case (t)
      0, 1: return 44;
      2: return 19;
      3: return 77;
      4: return 27;
      default: return 0;
    endcase
  endfunction

  function automatic int m_oh(input int t);
    case (t)
      0, 1: return 33;
      2: return 36;
      3: return 49;
      4: return 50;
      default: return 0;
    endcase
  endfunction

  function automatic int m_bot(input int t);
    case (t)
      0: return 380;
      1: return 350;
      default: return 400;
    endcase
  endfunction

  function automatic bit overlaps(input int en, input int t, input int pos, input int dp, input int beh);
    int dw, dh, left, top;
    dw   = beh ? 44 : 59;
    dh   = beh ? 47 : 30;
    left = pos - m_ow(t);
    top  = m_bot(t) - m_oh(t);
    return (en != 0) && (t < 5) && (pos > 64) && (left < 64 + dw) &&
           (dp - dh < m_bot(t)) && (top < dp);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_slot(input int s, input logic en, input logic [2:0] t, input logic [9:0] pos);
    case (s)
      0: begin bus_if.danger_en1 = en; bus_if.danger_type1 = t; bus_if.danger_pos1 = pos; end
      1: begin bus_if.danger_en2 = en; bus_if.danger_type2 = t; bus_if.danger_pos2 = pos; end
      default: begin bus_if.danger_en3 = en; bus_if.danger_type3 = t; bus_if.danger_pos3 = pos; end
    endcase
  endtask

  task automatic clear_slots();
    for (int s = 0; s < 3; s++) set_slot(s, 1'b0, 3'd5, 10'd0);
  endtask

  task automatic set_dino(input logic [9:0] p, input logic beh);
    bus_if.dino_pos      = p;
    bus_if.dino_behavior = beh;
  endtask

  task automatic new_game();
    clear_slots();
    bus_if.game_tick  = 1'b0;
    bus_if.game_state = 2'd3;
    cyc(2);
    bus_if.game_state = 2'd0;
    cyc(1);
    bus_if.game_state = 2'd1;
  endtask

  task automatic run_ticks(input int n);
    if (n > 0) begin
      bus_if.game_tick = 1'b1;
      cyc(n);
      bus_if.game_tick = 1'b0;
    end
  endtask

  task automatic observe(input int n, output int first_hit, output int pulses);
    first_hit = -1;
    pulses    = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      if (bus_if.hit === 1'b1 && first_hit < 0) first_hit = i;
      if (bus_if.hit_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic expect_detect(input string tag, input bit exp);
    int fh, np;
    observe(8, fh, np);
    check({tag, "_hit"}, 16'(bus_if.hit), 16'(exp));
    check({tag, "_pulses"}, 16'(np), exp ? 16'd1 : 16'd0);
    if (exp) check({tag, "_within5"}, 16'(fh >= 1 && fh <= 5), 16'd1);
  endtask

  int nt, dp, beh, en, ty, ps, fh, np;
  bit exp_any;

  initial begin
    rst = 1'b1;
    bus_if.game_tick  = 1'b0;
    bus_if.game_state = 2'd0;
    set_dino(10'd400, 1'b1);
    clear_slots();
    @(negedge clk);
    @(negedge clk);
    check("rst_hit", 16'(bus_if.hit), 16'd0);
    check("rst_pulse", 16'(bus_if.hit_pulse), 16'd0);
    check("rst_score", bus_if.score, 16'h0000);
    check("rst_hs", bus_if.high_score, 16'h0000);
    rst = 1'b0;
    cyc(1);

    // BIG cactus at the dino while standing on the ground, then while jumping
    new_game();
    set_dino(10'd400, 1'b1);
    set_slot(0, 1'b1, 3'd4, 10'd100);
    expect_detect("big_ground", 1'b1);
    check("big_ground_hs", bus_if.high_score, hs_exp(0));
    new_game();
    set_dino(10'd340, 1'b1);
    set_slot(0, 1'b1, 3'd4, 10'd100);
    expect_detect("big_jump", 1'b0);

    // High bird: sitting and standing pass under it, lifted dino hits it
    new_game();
    set_dino(10'd400, 1'b0);
    set_slot(1, 1'b1, 3'd1, 10'd90);
    expect_detect("hbird_sit", 1'b0);
    new_game();
    set_dino(10'd400, 1'b1);
    set_slot(2, 1'b1, 3'd1, 10'd90);
    expect_detect("hbird_stand", 1'b0);
    new_game();
    set_dino(10'd380, 1'b1);
    set_slot(2, 1'b1, 3'd1, 10'd90);
    expect_detect("hbird_lift", 1'b1);

    // High score across two games
    new_game();
    run_ticks(252);
    check("g1_score", bus_if.score, 16'h0042);
    set_dino(10'd400, 1'b1);
    set_slot(1, 1'b1, 3'd2, 10'd80);
    expect_detect("g1", 1'b1);
    hs_model = 42;
    check("g1_hs", bus_if.high_score, hs_exp(hs_model));
    new_game();
    cyc(1);
    check("g2_start_score", bus_if.score, 16'h0000);
    check("g2_start_hs", bus_if.high_score, hs_exp(hs_model));
    run_ticks(180);
    check("g2_score", bus_if.score, 16'h0030);
    set_slot(0, 1'b1, 3'd3, 10'd120);
    expect_detect("g2", 1'b1);
    check("g2_hs", bus_if.high_score, hs_exp(hs_model));

    // RESET landing on the clk of a detected overlap; then exact 3-clk latency
    clear_slots();
    bus_if.game_state = 2'd3;
    set_dino(10'd400, 1'b1);
    for (int s = 0; s < 3; s++) set_slot(s, 1'b1, 3'd4, 10'd100);
    cyc(2);
    bus_if.game_state = 2'd1;
    cyc(2);
    check("coinc_pre_hit", 16'(bus_if.hit), 16'd0);
    bus_if.game_state = 2'd3;
    cyc(1);
    check("coinc_hit", 16'(bus_if.hit), 16'd0);
    check("coinc_pulse", 16'(bus_if.hit_pulse), 16'd0);
    cyc(3);
    check("coinc_later_hit", 16'(bus_if.hit), 16'd0);
    bus_if.game_state = 2'd1;
    cyc(2);
    check("lat2_hit", 16'(bus_if.hit), 16'd0);
    cyc(1);
    check("lat3_hit", 16'(bus_if.hit), 16'd1);
    check("lat3_pulse", 16'(bus_if.hit_pulse), 16'd1);
    cyc(1);
    check("lat4_pulse", 16'(bus_if.hit_pulse), 16'd0);

    // game_tick on the clk where hit rises is not counted
    new_game();
    run_ticks(5);
    check("tk_pre_score", bus_if.score, 16'h0000);
    for (int s = 0; s < 3; s++) set_slot(s, 1'b1, 3'd4, 10'd100);
    cyc(2);
    bus_if.game_tick = 1'b1;
    cyc(1);
    bus_if.game_tick = 1'b0;
    check("tk_rise_hit", 16'(bus_if.hit), 16'd1);
    check("tk_rise_score", bus_if.score, 16'h0000);
    run_ticks(6);
    check("tk_after_hit_score", bus_if.score, 16'h0000);

    // Randomized games against the interval model
    for (int t = 0; t < 12; t++) begin
      new_game();
      nt = $urandom_range(400, 0);
      run_ticks(nt);
      check("rand_score", bus_if.score, to_bcd(nt / 6));
      dp  = $urandom_range(420, 300);
      beh = $urandom_range(1, 0);
      set_dino(10'(dp), 1'(beh));
      exp_any = 1'b0;
      for (int s = 0; s < 3; s++) begin
        en = $urandom_range(1, 0);
        ty = $urandom_range(5, 0);
        ps = $urandom_range(200, 40);
        set_slot(s, 1'(en), 3'(ty), 10'(ps));
        if (overlaps(en, ty, ps, dp, beh)) exp_any = 1'b1;
      end
      observe(8, fh, np);
      check("rand_hit", 16'(bus_if.hit), 16'(exp_any));
      check("rand_pulses", 16'(np), 16'(exp_any));
      if (exp_any) begin
        check("rand_within5", 16'(fh >= 1 && fh <= 5), 16'd1);
        if (nt / 6 > hs_model) hs_model = nt / 6;
      end
      check("rand_hs", bus_if.high_score, hs_exp(hs_model));
    end

    // Asynchronous rst in the middle of a game clears everything at once
    new_game();
    run_ticks(738);
    check("arst_pre_score", bus_if.score, 16'h0123);
    set_dino(10'd400, 1'b1);
    set_slot(0, 1'b1, 3'd4, 10'd100);
    expect_detect("arst_pre", 1'b1);
    if (123 > hs_model) hs_model = 123;
    check("arst_pre_hs", bus_if.high_score, hs_exp(hs_model));
    #2;
    rst = 1'b1;
    clear_slots();
    #1;
    check("arst_hit", 16'(bus_if.hit), 16'd0);
    check("arst_pulse", 16'(bus_if.hit_pulse), 16'd0);
    check("arst_score", bus_if.score, 16'h0000);
    check("arst_hs", bus_if.high_score, 16'h0000);
    hs_model = 0;
    @(negedge clk);
    rst = 1'b0;

    // Long run: BCD carries and saturation at 9999
    new_game();
    bus_if.game_tick = 1'b1;
    for (int k = 1; k <= 60006; k++) begin
      cyc(1);
      if (k == 60 || k == 600 || k == 6000 || k == 59994 || k == 60006)
        check("sat_score", bus_if.score, to_bcd(k / 6));
    end
    bus_if.game_tick = 1'b0;
    check("sat_hit", 16'(bus_if.hit), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
